// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle ADD/SUB/AND/XOR/SLL/SRA plus an iterative
// radix-2 shift-add multiplier with a start/busy/valid handshake for stalling.
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             kill_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic {
    IDLE,
    MUL_RUN
  } state_t;

  state_t           state_q;
  logic             busy_q;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    count_q;

  logic [WIDTH-1:0] alu_d;
  logic [WIDTH-1:0] acc_d;
  logic [SHW-1:0]   shamt;
  logic             last_iter;

  // Shifts only look at the low log2(WIDTH) bits of operand B.
  assign shamt = data2_i[SHW-1:0];

  always_comb begin
    alu_d = '0;
    case (ALUCtrl_i)
      OP_ADD:  alu_d = data1_i + data2_i;
      OP_SUB:  alu_d = data1_i - data2_i;
      OP_AND:  alu_d = data1_i & data2_i;
      OP_XOR:  alu_d = data1_i ^ data2_i;
      OP_SLL:  alu_d = data1_i << shamt;
      OP_SRA:  alu_d = $signed(data1_i) >>> shamt;
      default: alu_d = '0;
    endcase
  end

  assign acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last_iter = (count_q == CW'(WIDTH - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      zero_q   <= 1'b1;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // kill_i wins over a simultaneous start_i.
          if (start_i && !kill_i) begin
            if (ALUCtrl_i == OP_MUL) begin
              mcand_q  <= data1_i;
              mplier_q <= data2_i;
              acc_q    <= '0;
              count_q  <= '0;
              busy_q   <= 1'b1;
              state_q  <= MUL_RUN;
            end else begin
              data_q  <= alu_d;
              zero_q  <= (alu_d == '0);
              valid_q <= 1'b1;
            end
          end
        end
        MUL_RUN: begin
          if (kill_i) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + CW'(1);
            // Fixed WIDTH-iteration latency; no early exit on a zero multiplier.
            if (last_iter) begin
              data_q  <= acc_d;
              zero_q  <= (acc_d == '0);
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_alu_iterative.sv
// Scoreboard bench for alu_iterative: expected results are queued at issue time
// and popped when valid_o pulses; inputs change and outputs are sampled on negedge.
module tb_alu_iterative;

  localparam int W = 32;
  localparam logic [2:0] C_RSV = 3'b000;
  localparam logic [2:0] C_ADD = 3'b001;
  localparam logic [2:0] C_SUB = 3'b010;
  localparam logic [2:0] C_MUL = 3'b011;
  localparam logic [2:0] C_AND = 3'b100;
  localparam logic [2:0] C_XOR = 3'b101;
  localparam logic [2:0] C_SLL = 3'b110;
  localparam logic [2:0] C_SRA = 3'b111;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic         kill_i;
  logic [2:0]   ALUCtrl_i;
  logic [W-1:0] data1_i;
  logic [W-1:0] data2_i;
  logic         busy_o;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic         zero_o;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;

  alu_iterative #(.WIDTH(W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .kill_i    (kill_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .zero_o    (zero_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference for single-cycle ops; shifts are built one bit at a time.
  function automatic logic [W-1:0] model(input logic [2:0] c, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    case (c)
      C_ADD: r = a + b;
      C_SUB: r = a + ~b + 32'd1;
      C_AND: r = a & b;
      C_XOR: r = a ^ b;
      C_SLL: begin
        r = a;
        for (int i = 0; i < int'(b[4:0]); i++) r = {r[W-2:0], 1'b0};
      end
      C_SRA: begin
        r = a;
        for (int i = 0; i < int'(b[4:0]); i++) r = {r[W-1], r[W-1:1]};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Called at a negedge: presents a start for one cycle, returns at the next negedge.
  task automatic issue(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    ALUCtrl_i = c;
    data1_i   = a;
    data2_i   = b;
    start_i   = 1'b1;
    @(negedge clk_i);
    start_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; kill_i = 1'b0;
    ALUCtrl_i = C_RSV; data1_i = '0; data2_i = '0;
    repeat (2) @(negedge clk_i);
    total++;
    if ({busy_o, valid_o, data_o, zero_o} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state got busy=%b valid=%b data=%h zero=%b want 0 0 00000000 1",
               busy_o, valid_o, data_o, zero_o);
    end
    rst_i = 1'b0;
    @(negedge clk_i);
    $display("txn reset done");
  endtask

  task automatic test_add();
    exp_q.push_back(32'h0000000C);
    issue(C_ADD, 32'd5, 32'd7);
    exp_v = exp_q.pop_front();
    total++;
    if (valid_o !== 1'b1) begin bad++; $display("FAIL add_valid got %b want 1", valid_o); end
    total++;
    if (data_o !== exp_v) begin bad++; $display("FAIL add_data got %h want %h", data_o, exp_v); end
    total++;
    if (zero_o !== 1'b0) begin bad++; $display("FAIL add_zero got %b want 0", zero_o); end
    @(negedge clk_i);
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("FAIL add_valid_drop got %b want 0", valid_o); end
    total++;
    if (data_o !== exp_v) begin bad++; $display("FAIL add_hold got %h want %h", data_o, exp_v); end
    $display("txn ADD 5+7 -> %h", data_o);
  endtask

  task automatic test_single_cycle();
    logic [2:0]   ops [10];
    logic [W-1:0] as  [10];
    logic [W-1:0] bs  [10];
    logic [W-1:0] es  [10];
    logic [2:0]   c;
    logic [W-1:0] a, b;
    ops = '{C_SUB, C_SUB, C_SRA, C_SLL, C_AND, C_XOR, C_RSV, C_SRA, C_SLL, C_ADD};
    as  = '{32'd3, 32'd9, 32'h80000000, 32'h1, 32'hF0F0F0F0, 32'hF0F0F0F0,
            32'd1234, 32'h7FFFFFF0, 32'h3, 32'hFFFFFFFF};
    bs  = '{32'd5, 32'd9, 32'h24, 32'd31, 32'hFF00FF00, 32'hFF00FF00,
            32'd5678, 32'd4, 32'h21, 32'd1};
    es  = '{32'hFFFFFFFE, 32'h0, 32'hF8000000, 32'h80000000, 32'hF000F000,
            32'h0FF00FF0, 32'h0, 32'h07FFFFFF, 32'h6, 32'h0};
    for (int i = 0; i < 18; i++) begin
      if (i < 10) begin
        c = ops[i]; a = as[i]; b = bs[i];
        exp_q.push_back(es[i]);
      end else begin
        case ($urandom_range(0, 5))
          0: c = C_ADD;
          1: c = C_SUB;
          2: c = C_AND;
          3: c = C_XOR;
          4: c = C_SLL;
          default: c = C_SRA;
        endcase
        a = $urandom; b = $urandom;
        exp_q.push_back(model(c, a, b));
      end
      issue(c, a, b);
      exp_v = exp_q.pop_front();
      total++;
      if (valid_o !== 1'b1 || data_o !== exp_v || zero_o !== (exp_v == '0)) begin
        bad++;
        $display("FAIL op%0d_ctrl%0d got valid=%b data=%h zero=%b want 1 %h %b",
                 i, c, valid_o, data_o, zero_o, exp_v, (exp_v == '0));
      end
      $display("txn op=%0d a=%h b=%h -> %h", c, a, b, data_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_mul_ignore();
    int busy_cnt;
    int c;
    bit stray;
    exp_q.push_back(32'hFFFFFFFD);
    issue(C_MUL, 32'hFFFFFFFF, 32'd3);
    busy_cnt = 0; c = 0; stray = 0;
    while (busy_o === 1'b1 && c < 100) begin
      busy_cnt++;
      if (valid_o !== 1'b0) stray = 1;
      // Arrives at the DUT on edge N+5 and also scrambles the operand pins.
      if (c == 4) begin
        ALUCtrl_i = C_ADD; data1_i = 32'd1; data2_i = 32'd1; start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      c++;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    total++;
    if (busy_cnt != 32) begin bad++; $display("FAIL mul_busy_cycles got %0d want 32", busy_cnt); end
    total++;
    if (stray) begin bad++; $display("FAIL mul_stray_valid got 1 want 0"); end
    exp_v = exp_q.pop_front();
    total++;
    if (valid_o !== 1'b1 || data_o !== exp_v || zero_o !== 1'b0) begin
      bad++;
      $display("FAIL mul_result got valid=%b data=%h zero=%b want 1 %h 0", valid_o, data_o, zero_o, exp_v);
    end
    @(negedge clk_i);
    total++;
    if (valid_o !== 1'b0 || data_o !== exp_v) begin
      bad++;
      $display("FAIL mul_ignored_add got valid=%b data=%h want 0 %h", valid_o, data_o, exp_v);
    end
    $display("txn MUL ffffffff*3 -> %h busy=%0d", exp_v, busy_cnt);
  endtask

  task automatic test_kill();
    bit stray;
    issue(C_MUL, 32'd1234, 32'd5678);
    repeat (9) @(negedge clk_i);
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL kill_pre_busy got %b want 1", busy_o); end
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    total++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0 || data_o !== 32'hFFFFFFFD || zero_o !== 1'b0) begin
      bad++;
      $display("FAIL kill_mul got busy=%b valid=%b data=%h zero=%b want 0 0 fffffffd 0",
               busy_o, valid_o, data_o, zero_o);
    end
    exp_q.push_back(32'd5);
    issue(C_ADD, 32'd2, 32'd3);
    exp_v = exp_q.pop_front();
    total++;
    if (valid_o !== 1'b1 || data_o !== exp_v) begin
      bad++;
      $display("FAIL kill_then_add got valid=%b data=%h want 1 %h", valid_o, data_o, exp_v);
    end
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (valid_o !== 1'b0 || busy_o !== 1'b0) stray = 1;
    end
    total++;
    if (stray) begin bad++; $display("FAIL kill_stray got activity want none"); end
    // kill_i in IDLE discards a simultaneous start.
    ALUCtrl_i = C_ADD; data1_i = 32'd4; data2_i = 32'd4; start_i = 1'b1; kill_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; kill_i = 1'b0;
    total++;
    if (valid_o !== 1'b0 || data_o !== 32'd5) begin
      bad++;
      $display("FAIL kill_idle got valid=%b data=%h want 0 00000005", valid_o, data_o);
    end
    $display("txn MUL killed, ADD 2+3 -> %h", data_o);
  endtask

  task automatic test_async_reset();
    int c;
    issue(C_MUL, 32'd100, 32'd100);
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    total++;
    if ({busy_o, valid_o, data_o, zero_o} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
      bad++;
      $display("FAIL async_reset got busy=%b valid=%b data=%h zero=%b want 0 0 00000000 1",
               busy_o, valid_o, data_o, zero_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    exp_q.push_back(32'd42);
    issue(C_MUL, 32'd7, 32'd6);
    c = 0;
    while (valid_o !== 1'b1 && c < 100) begin
      @(negedge clk_i);
      c++;
    end
    exp_v = exp_q.pop_front();
    total++;
    if (c != 32) begin bad++; $display("FAIL mul7x6_latency got %0d want 32", c); end
    total++;
    if (data_o !== exp_v) begin bad++; $display("FAIL mul7x6_data got %h want %h", data_o, exp_v); end
    @(negedge clk_i);
    $display("txn reset mid-MUL, MUL 7*6 -> %0d", data_o);
  endtask

  task automatic test_back_to_back();
    int c;
    logic [W-1:0] a, b;
    exp_q.push_back(32'd15);
    issue(C_MUL, 32'd3, 32'd5);
    c = 0;
    while (valid_o !== 1'b1 && c < 100) begin
      @(negedge clk_i);
      c++;
    end
    exp_v = exp_q.pop_front();
    total++;
    if (valid_o !== 1'b1 || data_o !== exp_v) begin
      bad++;
      $display("FAIL b2b_mul got valid=%b data=%h want 1 %h", valid_o, data_o, exp_v);
    end
    // Start accepted in the same cycle valid_o is high.
    exp_q.push_back(32'd2);
    issue(C_ADD, 32'd1, 32'd1);
    exp_v = exp_q.pop_front();
    total++;
    if (valid_o !== 1'b1 || data_o !== exp_v) begin
      bad++;
      $display("FAIL b2b_after_mul got valid=%b data=%h want 1 %h", valid_o, data_o, exp_v);
    end
    exp_q.push_back(32'd30);
    ALUCtrl_i = C_ADD; data1_i = 32'd10; data2_i = 32'd20; start_i = 1'b1;
    @(negedge clk_i);
    exp_v = exp_q.pop_front();
    total++;
    if (valid_o !== 1'b1 || data_o !== exp_v) begin
      bad++;
      $display("FAIL b2b_first got valid=%b data=%h want 1 %h", valid_o, data_o, exp_v);
    end
    exp_q.push_back(32'd0);
    ALUCtrl_i = C_SUB; data1_i = 32'd9; data2_i = 32'd9;
    @(negedge clk_i);
    start_i = 1'b0;
    exp_v = exp_q.pop_front();
    total++;
    if (valid_o !== 1'b1 || data_o !== exp_v || zero_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second got valid=%b data=%h zero=%b want 1 %h 1", valid_o, data_o, zero_o, exp_v);
    end
    @(negedge clk_i);
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("FAIL b2b_drop got %b want 0", valid_o); end
    for (int k = 0; k < 3; k++) begin
      a = $urandom; b = $urandom;
      exp_q.push_back(a * b);
      issue(C_MUL, a, b);
      c = 0;
      while (valid_o !== 1'b1 && c < 100) begin
        @(negedge clk_i);
        c++;
      end
      exp_v = exp_q.pop_front();
      total++;
      if (valid_o !== 1'b1 || data_o !== exp_v) begin
        bad++;
        $display("FAIL rand_mul%0d got valid=%b data=%h want 1 %h", k, valid_o, data_o, exp_v);
      end
      $display("txn MUL %h*%h -> %h", a, b, data_o);
    end
    @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_add();
    test_single_cycle();
    test_mul_ignore();
    test_kill();
    test_async_reset();
    test_back_to_back();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Execute-stage ALU that consumes the 3-bit ALU control code produced by the ALU control decoder.
- Performs ADD/SUB/AND/XOR/SLL/SRA in one cycle.
- Performs MUL with an iterative radix-2 shift-add engine over WIDTH cycles.
- Issues a start/busy/valid handshake so the hazard unit can stall the pipeline while MUL is running.

Parameters:
- WIDTH, 32, operand and result width; also the MUL iteration count.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  launch operation with the current ALUCtrl_i, data1_i and data2_i.
- kill_i  input  1  synchronous abort of an in-flight MUL (pipeline flush).
- ALUCtrl_i  input  3  001 ADD, 010 SUB, 011 MUL, 100 AND, 101 XOR, 110 SLL, 111 SRA, 000 reserved.
- data1_i  input  WIDTH  operand A (rs1).
- data2_i  input  WIDTH  operand B (rs2 or immediate).
- busy_o  output  1  MUL in progress; pipeline must stall.
- valid_o  output  1  one-cycle pulse: data_o holds a new result.
- data_o  output  WIDTH  registered result; holds last value between pulses.
- zero_o  output  1  registered (result == 0), updated together with data_o.

Behaviour:
- Reset (async, any state): state=IDLE, busy_o=0, valid_o=0, data_o=0, zero_o=1, MUL accumulator/multiplicand/multiplier/counter=0.
- States: IDLE, MUL_RUN.
- IDLE with start_i=1 and kill_i=0, single-cycle op: result registered at edge N; valid_o=1 for the cycle after edge N; stay IDLE.
  - ADD: A+B mod 2^WIDTH.
  - SUB: A-B mod 2^WIDTH.
  - AND, XOR: bitwise.
  - SLL: A << B[4:0].
  - SRA: arithmetic A >>> B[4:0]; sign bit replicated.
  - Only B[log2(WIDTH)-1:0] is used for shifts.
  - Reserved code 000: result 0, valid_o still pulses.
- IDLE with start_i=1 and ALUCtrl_i=MUL:
  - At edge N: load mcand=A, mplier=B, acc=0, count=0; go to MUL_RUN; busy_o=1 from edge N.
- MUL_RUN, each edge:
  - If mplier[0], acc += mcand.
  - mcand <<= 1; mplier >>= 1 (logical); count++.
  - After iteration WIDTH (edge N+WIDTH): data_o = final acc (low WIDTH bits of A*B, unsigned/signed identical), valid_o=1 for one cycle, busy_o=0, go to IDLE.
  - Latency is exactly WIDTH edges after the start edge; no early termination.
- start_i while busy_o=1: ignored; operands not re-sampled.
- Back-to-back: start_i is accepted in the same cycle valid_o is high. A new single-cycle result makes valid_o stay high for consecutive cycles.
- kill_i=1 in MUL_RUN: at next edge go to IDLE, busy_o=0, no valid_o pulse, data_o/zero_o unchanged.
- kill_i=1 in IDLE: any simultaneous start_i is discarded (kill wins); valid_o=0 next cycle.
- valid_o is never high in two consecutive cycles unless two starts are accepted back-to-back.
- data_o changes only on a valid_o pulse or on reset.
- Operand inputs need not stay stable after the start edge; all MUL operands are captured internally.

Test Plan:
- ADD 5+7, start one cycle -> next cycle valid_o=1, data_o=0x0000000C, zero_o=0; following cycle valid_o=0, data_o holds 0xC.
- SUB 3-5 -> data_o=0xFFFFFFFE. SUB 9-9 -> data_o=0, zero_o=1.
- SRA data1=0x80000000, data2=0x00000024 -> shift 4, data_o=0xF8000000. SLL 0x1<<31 -> 0x80000000.
- MUL 0xFFFFFFFF*3 -> busy_o high for exactly 32 cycles; valid_o pulses once at edge N+32 with data_o=0xFFFFFFFD. A start_i (ADD 1+1) at cycle N+5 is ignored; data_o is not 2.
- MUL 1234*5678 with kill_i at cycle N+10 -> busy_o drops at the next edge, no valid_o, data_o keeps its prior value. A fresh ADD immediately afterwards completes normally.
- rst_i asserted asynchronously mid-MUL (between edges) -> busy_o, valid_o and data_o clear immediately. After release, MUL 7*6 -> data_o=42 after 32 cycles.
